spoc_perm_sequencer: RTL and testbench

- Round/step sequencer for the sLiSCP-light-192 permutation inside the SpoC-64 datapath.
- Accepts a start pulse from the controller, then drives the round enables, round/step indices and round/step constants for the permutation datapath.
- Returns a one-cycle done pulse; this is the controller's perm_done.
- Owns all permutation timing, so the controller sees only start/busy/done.

---
 rtl/spoc_pkg.sv | 25 ++
 rtl/spoc_lfsr6.sv | 43 ++++
 rtl/spoc_perm_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spoc_perm_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spoc_pkg.sv
// Shared definitions for the SpoC-64 permutation sequencer: FSM encoding,
// LFSR seeds and taps, default permutation geometry.
package spoc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } perm_state_e;

    localparam logic [5:0] RC_SEED = 6'h3F;
    localparam logic [5:0] SC_SEED = 6'h07;

    // Feedback taps: new bit = b5 ^ b4, shifted in at bit 0
    localparam int unsigned LFSR_TAP_HI = 5;
    localparam int unsigned LFSR_TAP_LO = 4;

    localparam int unsigned NUM_STEPS_DEFAULT       = 18;
    localparam int unsigned ROUNDS_PER_STEP_DEFAULT = 6;

    function automatic logic [5:0] lfsr6_next(input logic [5:0] s);
        return {s[4:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/spoc_lfsr6.sv
// 6-bit Fibonacci LFSR with synchronous load and a step enable that
// advances the register STEPS_PER_EN shifts per enabled cycle.
module spoc_lfsr6
    import spoc_pkg::*;
#(
    parameter int unsigned STEPS_PER_EN = 1,
    parameter logic [5:0]  SEED         = RC_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [5:0] state
);

    logic [5:0] state_q, state_d, adv;

    // Next state: load wins over step; step applies STEPS_PER_EN shifts
    always_comb begin
        adv = state_q;
        for (int unsigned i = 0; i < STEPS_PER_EN; i++) begin
            adv = lfsr6_next(adv);
        end
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = adv;
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/spoc_perm_sequencer.sv
// Round/step sequencer for the sLiSCP-light-192 permutation of SpoC-64.
// Drives round enables, indices and round/step constants; done is the
// controller's perm_done. Optional macro SPOC_PERM_ABORT_EN adds an abort input.
module spoc_perm_sequencer
    import spoc_pkg::*;
#(
    parameter int unsigned NUM_STEPS       = NUM_STEPS_DEFAULT,
    parameter int unsigned ROUNDS_PER_STEP = ROUNDS_PER_STEP_DEFAULT,
    parameter int unsigned UNROLL          = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SPOC_PERM_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              en_round,
    output logic              step_last,
    output logic [2:0]        round_idx,
    output logic [4:0]        step_idx,
    output logic [UNROLL-1:0] rc,
    output logic [5:0]        sc
);

    if (UNROLL == 0 || UNROLL > ROUNDS_PER_STEP || (ROUNDS_PER_STEP % UNROLL) != 0) begin : g_bad_unroll
        $error("UNROLL must divide ROUNDS_PER_STEP");
    end
    if (ROUNDS_PER_STEP == 0 || ROUNDS_PER_STEP > 8) begin : g_bad_rounds
        $error("ROUNDS_PER_STEP must fit a 3-bit round index");
    end
    if (NUM_STEPS == 0 || NUM_STEPS > 32) begin : g_bad_steps
        $error("NUM_STEPS must fit a 5-bit step index");
    end

    localparam logic [2:0] RoundStep = 3'(UNROLL);
    localparam logic [2:0] RoundLast = 3'(ROUNDS_PER_STEP - UNROLL);
    localparam logic [4:0] StepLast  = 5'(NUM_STEPS - 1);

    perm_state_e state_q, state_d;
    logic [2:0]  round_idx_q, round_idx_d;
    logic [4:0]  step_idx_q, step_idx_d;
    logic        reload, rc_step, sc_step, abort_req;
    logic        busy_d, done_d, en_round_d, step_last_d;
    logic        busy_q, done_q, en_round_q, step_last_q;
    logic [5:0]  rc_state, sc_state, rc_walk;

`ifdef SPOC_PERM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State and index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            round_idx_q <= '0;
            step_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            step_idx_q  <= step_idx_d;
        end
    end

    // Next-state, index and LFSR control
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        step_idx_d  = step_idx_q;
        reload      = 1'b0;
        rc_step     = 1'b0;
        sc_step     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    reload      = 1'b1;
                    round_idx_d = '0;
                    step_idx_d  = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                rc_step = 1'b1;
                if (round_idx_q == RoundLast) begin
                    round_idx_d = '0;
                    sc_step     = 1'b1;
                    if (step_idx_q == StepLast) begin
                        step_idx_d = '0;
                        state_d    = StDone;
                    end else begin
                        step_idx_d = step_idx_q + 5'd1;
                    end
                end else begin
                    round_idx_d = round_idx_q + RoundStep;
                end
            end
            StDone: begin
                // start here chains straight into the next run with no bubble
                if (start) begin
                    reload      = 1'b1;
                    round_idx_d = '0;
                    step_idx_d  = '0;
                    state_d     = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort_req) begin
            state_d     = StIdle;
            round_idx_d = '0;
            step_idx_d  = '0;
            reload      = 1'b0;
            rc_step     = 1'b0;
            sc_step     = 1'b0;
        end
    end

    // Outputs decoded from next state so they are registered with it
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        en_round_d  = (state_d == StRun);
        step_last_d = en_round_d && (round_idx_d == RoundLast);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_round_q  <= 1'b0;
            step_last_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_round_q  <= en_round_d;
            step_last_q <= step_last_d;
        end
    end

    spoc_lfsr6 #(
        .STEPS_PER_EN (UNROLL),
        .SEED         (RC_SEED)
    ) u_rc_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (reload),
        .step  (rc_step),
        .state (rc_state)
    );

    spoc_lfsr6 #(
        .STEPS_PER_EN (1),
        .SEED         (SC_SEED)
    ) u_sc_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (reload),
        .step  (sc_step),
        .state (sc_state)
    );

    // rc[i] is the bit sitting in position 0 after i shifts of the rc LFSR
    always_comb begin
        rc_walk = rc_state;
        rc      = '0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            rc[i]   = rc_walk[0];
            rc_walk = lfsr6_next(rc_walk);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign en_round  = en_round_q;
    assign step_last = step_last_q;
    assign round_idx = round_idx_q;
    assign step_idx  = step_idx_q;
    assign sc        = sc_state;

endmodule

// File: tb/tb_spoc_perm_sequencer.sv
// Scoreboard bench for spoc_perm_sequencer: UNROLL=1 and UNROLL=2 instances.
module tb_spoc_perm_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2;
`ifdef SPOC_PERM_ABORT_EN
    logic abort;
`endif

    logic       d1_busy, d1_done, d1_en, d1_sl;
    logic [2:0] d1_ridx;
    logic [4:0] d1_sidx;
    logic [0:0] d1_rc;
    logic [5:0] d1_sc;

    logic       d2_busy, d2_done, d2_en, d2_sl;
    logic [2:0] d2_ridx;
    logic [4:0] d2_sidx;
    logic [1:0] d2_rc;
    logic [5:0] d2_sc;

    spoc_perm_sequencer #(.NUM_STEPS(18), .ROUNDS_PER_STEP(6), .UNROLL(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SPOC_PERM_ABORT_EN
        .abort     (1'b0),
`endif
        .start     (start),
        .busy      (d1_busy),
        .done      (d1_done),
        .en_round  (d1_en),
        .step_last (d1_sl),
        .round_idx (d1_ridx),
        .step_idx  (d1_sidx),
        .rc        (d1_rc),
        .sc        (d1_sc)
    );

    spoc_perm_sequencer #(.NUM_STEPS(18), .ROUNDS_PER_STEP(6), .UNROLL(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
`ifdef SPOC_PERM_ABORT_EN
        .abort     (abort),
`endif
        .start     (start2),
        .busy      (d2_busy),
        .done      (d2_done),
        .en_round  (d2_en),
        .step_last (d2_sl),
        .round_idx (d2_ridx),
        .step_idx  (d2_sidx),
        .rc        (d2_rc),
        .sc        (d2_sc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int cyc; int dut;
        bit en; bit sl; bit busy; bit dn;
        bit idx_chk; int ridx; int sidx;
        bit rc_chk; int rc;
        bit sc_chk; int sc;
    } snap_t;

    snap_t snap_q[$];
    int    done_q[$];
    int    done2_q[$];

    // Hand-derived LFSR outputs from seeds 3F (rc) and 07 (sc)
    int rc1_tab [0:6] = '{1, 0, 0, 0, 0, 0, 1};
    int rc2_tab [0:3] = '{1, 0, 0, 1};
    int sc_tab  [0:3] = '{7, 14, 28, 57};

    task automatic push_run(input int dut, input int t0, input int unroll,
                            input int last_k, input bit with_done);
        int rpc;
        int len;
        rpc = 6 / unroll;
        len = 108 / unroll;
        for (int k = 1; k <= last_k; k++) begin
            snap_t s;
            s = '{default: 0};
            s.cyc  = t0 + k;
            s.dut  = dut;
            s.en   = (k <= len);
            s.sl   = (k <= len) && (k % rpc == 0);
            s.busy = (k <= len + 1);
            s.dn   = (k == len + 1);
            s.idx_chk = s.en;
            s.ridx = ((k - 1) % rpc) * unroll;
            s.sidx = (k - 1) / rpc;
            if (unroll == 1 && k <= 7) begin
                s.rc_chk = 1'b1;
                s.rc = rc1_tab[k-1];
            end else if (unroll == 2 && k <= 4) begin
                s.rc_chk = 1'b1;
                s.rc = rc2_tab[k-1];
            end
            if (s.en && s.sidx < 4 && ((k - 1) % rpc == 0)) begin
                s.sc_chk = 1'b1;
                s.sc = sc_tab[s.sidx];
            end
            snap_q.push_back(s);
        end
        if (with_done) begin
            if (dut == 0) done_q.push_back(t0 + len + 1);
            else          done2_q.push_back(t0 + len + 1);
        end
    endtask

    task automatic push_idle(input int dut, input int c0, input int c1,
                             input bit idx_chk, input bit seed_chk);
        for (int c = c0; c <= c1; c++) begin
            snap_t s;
            s = '{default: 0};
            s.cyc = c;
            s.dut = dut;
            s.idx_chk = idx_chk;
            s.rc_chk = seed_chk;
            s.rc = 1;
            s.sc_chk = seed_chk;
            s.sc = 7;
            snap_q.push_back(s);
        end
    endtask

    task automatic check_snap(input snap_t s);
        int en, sl, bz, dn, ri, si, r, c;
        bit ok;
        if (s.dut == 0) begin
            en = int'(d1_en); sl = int'(d1_sl); bz = int'(d1_busy); dn = int'(d1_done);
            ri = int'(d1_ridx); si = int'(d1_sidx); r = int'(d1_rc); c = int'(d1_sc);
        end else begin
            en = int'(d2_en); sl = int'(d2_sl); bz = int'(d2_busy); dn = int'(d2_done);
            ri = int'(d2_ridx); si = int'(d2_sidx); r = int'(d2_rc); c = int'(d2_sc);
        end
        ok = (s.cyc == cyc) && en == int'(s.en) && sl == int'(s.sl) && bz == int'(s.busy)
             && dn == int'(s.dn) && (!s.idx_chk || (ri == s.ridx && si == s.sidx))
             && (!s.rc_chk || r == s.rc) && (!s.sc_chk || c == s.sc);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL snap dut%0d cyc %0d (now %0d): got en=%0d sl=%0d busy=%0d done=%0d ridx=%0d sidx=%0d rc=%0d sc=%0h; want en=%0d sl=%0d busy=%0d done=%0d ridx=%0d sidx=%0d rc=%0d sc=%0h",
                     s.dut, s.cyc, cyc, en, sl, bz, dn, ri, si, r, c,
                     s.en, s.sl, s.busy, s.dn, s.ridx, s.sidx, s.rc, s.sc);
        end
    endtask

    // Monitor: per-cycle snapshots plus done-pulse transactions
    always @(negedge clk) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            check_snap(snap_q.pop_front());
        end
        if (d1_done) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL done1: unexpected pulse at cyc %0d, want none", cyc);
            end else if (done_q[0] != cyc) begin
                fails++;
                $display("FAIL done1: pulse at cyc %0d, want cyc %0d", cyc, done_q.pop_front());
            end else begin
                void'(done_q.pop_front());
            end
        end
        if (d2_done) begin
            tests++;
            if (done2_q.size() == 0) begin
                fails++;
                $display("FAIL done2: unexpected pulse at cyc %0d, want none", cyc);
            end else if (done2_q[0] != cyc) begin
                fails++;
                $display("FAIL done2: pulse at cyc %0d, want cyc %0d", cyc, done2_q.pop_front());
            end else begin
                void'(done2_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int which, input int at);
        wait_cyc(at);
        case (which)
            0: start = 1'b1;
            1: start2 = 1'b1;
`ifdef SPOC_PERM_ABORT_EN
            2: abort = 1'b1;
`endif
            default: ;
        endcase
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
`ifdef SPOC_PERM_ABORT_EN
        abort  = 1'b0;
`endif
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
`ifdef SPOC_PERM_ABORT_EN
        abort = 1'b0;
`endif
        for (int c = 1; c <= 2; c++) begin
            push_idle(0, c, c, 1'b1, 1'b1);
            push_idle(1, c, c, 1'b1, 1'b1);
        end
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);

        // Basic run
        t0 = cyc;
        push_run(0, t0, 1, 110, 1'b1);
        pulse(0, t0);
        wait_cyc(t0 + 112);

        // Back-to-back: start in the done cycle
        t0 = cyc;
        push_run(0, t0, 1, 109, 1'b1);
        push_run(0, t0 + 109, 1, 110, 1'b1);
        pulse(0, t0);
        pulse(0, t0 + 109);
        wait_cyc(t0 + 109 + 112);

        // start during RUN is ignored
        t0 = cyc;
        push_run(0, t0, 1, 112, 1'b1);
        pulse(0, t0);
        pulse(0, t0 + 20);
        pulse(0, t0 + 50);
        wait_cyc(t0 + 114);

        // Async reset mid-run, then a full run afterwards
        t0 = cyc;
        push_run(0, t0, 1, 39, 1'b0);
        push_idle(0, t0 + 40, t0 + 43, 1'b1, 1'b1);
        pulse(0, t0);
        wait_cyc(t0 + 40);
        #2;
        rst = 1'b1;
        wait_cyc(t0 + 42);
        rst = 1'b0;
        wait_cyc(t0 + 45);
        t0 = cyc;
        push_run(0, t0, 1, 110, 1'b1);
        pulse(0, t0);
        wait_cyc(t0 + 112);

        // UNROLL=2 instance
        t0 = cyc;
        push_run(1, t0, 2, 58, 1'b1);
        pulse(1, t0);
        wait_cyc(t0 + 60);

`ifdef SPOC_PERM_ABORT_EN
        // Abort mid-run on the UNROLL=2 instance
        t0 = cyc;
        push_run(1, t0, 2, 30, 1'b0);
        push_idle(1, t0 + 31, t0 + 60, 1'b1, 1'b0);
        pulse(1, t0);
        pulse(2, t0 + 30);
        wait_cyc(t0 + 62);
`endif

        wait_cyc(cyc + 3);
        tests++;
        if (done_q.size() != 0 || done2_q.size() != 0 || snap_q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending done1=%0d done2=%0d snaps=%0d, want 0 0 0",
                     done_q.size(), done2_q.size(), snap_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
